pipe_hazard_sched: RTL and testbench

//  Central stall/flush scheduler for the 5-stage MIPS pipeline. Sits beside the forwarding unit.

---
 rtl/pipe_hazard_sched_pkg.sv | 15 +
 rtl/pipe_hazard_sched_if.sv | 34 +++
 rtl/pipe_hazard_sched_md_busy_timer.sv | 66 ++++++
 rtl/pipe_hazard_sched.sv | 65 ++++++
 tb/tb_pipe_hazard_sched.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_sched_pkg.sv
// Shared definitions for the pipeline hazard scheduler: mult/div state
// encoding and default latencies/widths.
package pipe_hazard_sched_pkg;

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_MD_BUSY = 1'b1
   } md_state_t;

   localparam int MULT_CYCLES_DEF = 4;
   localparam int DIV_CYCLES_DEF  = 32;
   localparam int CNT_W_DEF       = 6;
   localparam int PERF_W_DEF      = 16;

endpackage

// File: rtl/pipe_hazard_sched_if.sv
// Hazard inputs from the ID/EX stages and the stall/flush/mult-div controls
// returned to the pipeline. The pipeline side is master, the scheduler slave.
interface pipe_hazard_sched_if #(
   parameter int PERF_W = 16
);
   logic              Ex_MemRead;
   logic [4:0]        Ex_Rt;
   logic [4:0]        ID_Rs;
   logic [4:0]        ID_Rt;
   logic              Ex_BranchTaken;
   logic              Ex_MulDiv;
   logic              Ex_IsDiv;
   logic              ID_HiLoUse;
   logic              PC_sleep;
   logic              IF_ID_sleep;
   logic              IF_ID_flush;
   logic              ID_Ex_flush;
   logic              MD_start;
   logic              MD_busy;
   logic              MD_done;
   logic [PERF_W-1:0] stall_cycles;

   modport master (
      output Ex_MemRead, Ex_Rt, ID_Rs, ID_Rt, Ex_BranchTaken, Ex_MulDiv, Ex_IsDiv, ID_HiLoUse,
      input  PC_sleep, IF_ID_sleep, IF_ID_flush, ID_Ex_flush, MD_start, MD_busy, MD_done,
             stall_cycles
   );

   modport slave (
      input  Ex_MemRead, Ex_Rt, ID_Rs, ID_Rt, Ex_BranchTaken, Ex_MulDiv, Ex_IsDiv, ID_HiLoUse,
      output PC_sleep, IF_ID_sleep, IF_ID_flush, ID_Ex_flush, MD_start, MD_busy, MD_done,
             stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_sched_md_busy_timer.sv
// HI/LO occupancy timer: loads the operation latency on a start, counts down
// while busy and flags the final busy cycle as done.
module md_busy_timer
   import pipe_hazard_sched_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic is_div,
   output logic busy,
   output logic done
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   md_state_t        state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;

   // State and counter registers; reset abandons any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
      end
   end

   // Next state: a start is accepted only when idle, so a stray start while
   // busy is ignored.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         S_IDLE: begin
            if (load) begin
               cnt_next   = is_div ? DIV_LOAD : MULT_LOAD;
               state_next = S_MD_BUSY;
            end
         end
         S_MD_BUSY: begin
            if (cnt_reg == CNT_ONE) begin
               cnt_next   = '0;
               state_next = S_IDLE;
            end else begin
               cnt_next = cnt_reg - CNT_ONE;
            end
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   assign busy = (state_reg == S_MD_BUSY);
   assign done = busy && (cnt_reg == CNT_ONE);

endmodule

// File: rtl/pipe_hazard_sched.sv
// Stall/flush scheduler: merges load-use, taken-branch and HI/LO occupancy
// hazards into PC/IF_ID/ID_EX controls and counts stall cycles.
module pipe_hazard_sched
   import pipe_hazard_sched_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int PERF_W      = PERF_W_DEF
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_sched_if.slave hz
);

   logic              md_start, md_busy, md_done;
   logic              loaduse, hilo, branch, stall;
   logic              pc_sleep;
   logic [PERF_W-1:0] stall_reg;

   md_busy_timer #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (md_start),
      .is_div (hz.Ex_IsDiv),
      .busy   (md_busy),
      .done   (md_done)
   );

   // Hazard detection and priority merge. Combinational terms are gated by
   // rst_n so every output is quiet while reset is held. The done cycle does
   // not stall: HI/LO is valid when the waiting instruction reaches EX.
   always_comb begin
      md_start = rst_n && hz.Ex_MulDiv && !md_busy;
      loaduse  = hz.Ex_MemRead && (hz.Ex_Rt != 5'd0) &&
                 ((hz.Ex_Rt == hz.ID_Rs) || (hz.Ex_Rt == hz.ID_Rt));
      hilo     = hz.ID_HiLoUse && ((md_busy && !md_done) || md_start);
      branch   = rst_n && hz.Ex_BranchTaken;
      stall    = rst_n && (loaduse || hilo);
      pc_sleep = !branch && stall;
   end

   assign hz.PC_sleep    = pc_sleep;
   assign hz.IF_ID_sleep = pc_sleep;
   assign hz.IF_ID_flush = branch;
   assign hz.ID_Ex_flush = branch || stall;
   assign hz.MD_start    = md_start;
   assign hz.MD_busy     = md_busy;
   assign hz.MD_done     = md_done;
   assign hz.stall_cycles = stall_reg;

   // Saturating stall-cycle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_reg <= '0;
      end else if (pc_sleep && !(&stall_reg)) begin
         stall_reg <= stall_reg + PERF_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Bench for pipe_hazard_sched: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
module tb_pipe_hazard_sched;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   pipe_hazard_sched_if #(.PERF_W(16)) hz();

   pipe_hazard_sched dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   always #5 clk = ~clk;

   // Model: an operation is tracked by its age in cycles since the start edge.
   bit m_active = 1'b0;
   int m_age = 0;
   int m_len = 0;
   int m_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected {PC_sleep, IF_ID_sleep, IF_ID_flush, ID_Ex_flush, MD_start, MD_busy, MD_done}
   function automatic logic [6:0] model_out();
      logic br, lu, hl, st, busy, done, start;
      if (!rst_n) return 7'd0;
      busy  = m_active;
      done  = m_active && (m_age == m_len - 1);
      start = !m_active && hz.Ex_MulDiv;
      lu    = hz.Ex_MemRead && (hz.Ex_Rt != 0) && (hz.Ex_Rt == hz.ID_Rs || hz.Ex_Rt == hz.ID_Rt);
      hl    = hz.ID_HiLoUse && ((busy && !done) || start);
      br    = hz.Ex_BranchTaken;
      st    = lu || hl;
      return {!br && st, !br && st, br, br || st, start, busy, done};
   endfunction

   function automatic logic [6:0] dut_out();
      return {hz.PC_sleep, hz.IF_ID_sleep, hz.IF_ID_flush, hz.ID_Ex_flush,
              hz.MD_start, hz.MD_busy, hz.MD_done};
   endfunction

   // Model state update at each clock edge, cleared by reset.
   always @(posedge clk or negedge rst_n) begin
      logic [6:0] e;
      if (!rst_n) begin
         m_active = 1'b0;
         m_age    = 0;
         m_cnt    = 0;
      end else begin
         e = model_out();
         if (e[6] && m_cnt < 65535) m_cnt++;
         if (m_active) begin
            if (m_age == m_len - 1) m_active = 1'b0;
            else m_age++;
         end else if (hz.Ex_MulDiv) begin
            m_active = 1'b1;
            m_age    = 1;
            m_len    = hz.Ex_IsDiv ? 32 : 4;
         end
      end
   end

   // Every-cycle compare against the model.
   always @(negedge clk) begin
      check("controls", 32'(dut_out()), 32'(model_out()));
      check("stall_cycles", 32'(hz.stall_cycles), 32'(m_cnt));
   end

   task automatic clear_inputs();
      hz.Ex_MemRead = 0; hz.Ex_Rt = 0; hz.ID_Rs = 0; hz.ID_Rt = 0;
      hz.Ex_BranchTaken = 0; hz.Ex_MulDiv = 0; hz.Ex_IsDiv = 0; hz.ID_HiLoUse = 0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #2 rst_n = 0;
      clear_inputs();
      repeat (2) @(negedge clk);
      #2 rst_n = 1;
      next_cycle();
   endtask

   initial begin
      int stalls, busy_n, done_at, starts;
      clear_inputs();
      // Reset gating: live hazard inputs must not reach the outputs.
      hz.Ex_MulDiv = 1; hz.Ex_MemRead = 1; hz.Ex_Rt = 4; hz.ID_Rs = 4; hz.Ex_BranchTaken = 0;
      #8;
      check("reset_outputs", 32'(dut_out()), 32'd0);
      check("reset_stall_cycles", 32'(hz.stall_cycles), 32'd0);
      clear_inputs();
      #15 rst_n = 1;
      next_cycle();

      // 1: load-use on Rs stalls one cycle.
      hz.Ex_MemRead = 1; hz.Ex_Rt = 8; hz.ID_Rs = 8; hz.ID_Rt = 9;
      @(negedge clk);
      check("t1_stall", 32'(dut_out()), 32'b1101000);
      check("t1_cnt_before", 32'(hz.stall_cycles), 32'd0);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      check("t1_release", 32'(hz.PC_sleep), 32'd0);
      check("t1_cnt_after", 32'(hz.stall_cycles), 32'd1);
      $display("test 1 load-use done");

      // 2: load to $zero never stalls.
      next_cycle();
      hz.Ex_MemRead = 1; hz.Ex_Rt = 0; hz.ID_Rs = 0; hz.ID_Rt = 0;
      @(negedge clk);
      check("t2_zero_reg", 32'(dut_out()), 32'd0);
      $display("test 2 zero register done");

      // 3: mult then mflo.
      next_cycle();
      clear_inputs();
      stalls = 0; done_at = -1; starts = 0;
      for (int k = 0; k < 8; k++) begin
         hz.Ex_MulDiv = (k == 0); hz.ID_HiLoUse = 1;
         @(negedge clk);
         stalls += int'(hz.PC_sleep);
         starts += int'(hz.MD_start);
         if (hz.MD_done) done_at = k;
         if (k == 4) check("t3_mflo_issues", 32'(hz.PC_sleep), 32'd0);
         next_cycle();
      end
      check("t3_stalls", 32'(stalls), 32'd3);
      check("t3_done_at", 32'(done_at), 32'd3);
      check("t3_starts", 32'(starts), 32'd1);
      $display("test 3 mult/mflo done");

      // 4: div with unrelated stream, then mfhi at cnt==5.
      clear_inputs();
      stalls = 0; busy_n = 0; done_at = -1;
      for (int k = 0; k < 40; k++) begin
         hz.Ex_MulDiv = (k == 0); hz.Ex_IsDiv = 1;
         hz.ID_HiLoUse = (k >= 27 && k <= 32);
         @(negedge clk);
         stalls += int'(hz.PC_sleep);
         busy_n += int'(hz.MD_busy);
         if (hz.MD_done) done_at = k;
         next_cycle();
      end
      check("t4_busy_cycles", 32'(busy_n), 32'd31);
      check("t4_mfhi_stalls", 32'(stalls), 32'd4);
      check("t4_done_at", 32'(done_at), 32'd31);
      $display("test 4 div/mfhi done");

      // 5: taken branch beats load-use and HI/LO stall; div continues.
      clear_inputs();
      done_at = -1;
      for (int k = 0; k < 35; k++) begin
         clear_inputs();
         hz.Ex_MulDiv = (k == 0); hz.Ex_IsDiv = 1;
         if (k == 5) begin
            hz.Ex_BranchTaken = 1; hz.Ex_MemRead = 1; hz.Ex_Rt = 3; hz.ID_Rs = 3;
            hz.ID_HiLoUse = 1;
         end
         @(negedge clk);
         if (k == 5) check("t5_branch", 32'(dut_out()), 32'b0011010);
         if (hz.MD_done) done_at = k;
         next_cycle();
      end
      check("t5_done_at", 32'(done_at), 32'd31);
      $display("test 5 branch priority done");

      // 6: asynchronous reset at cnt==10 of a div.
      clear_inputs();
      done_at = -1;
      for (int k = 0; k < 22; k++) begin
         hz.Ex_MulDiv = (k == 0); hz.Ex_IsDiv = 1;
         next_cycle();
      end
      hz.Ex_MulDiv = 1; hz.Ex_MemRead = 1; hz.Ex_Rt = 2; hz.ID_Rt = 2; hz.ID_HiLoUse = 1;
      @(negedge clk);
      check("t6_pre_busy", 32'(hz.MD_busy), 32'd1);
      #2 rst_n = 0;
      #1;
      check("t6_async_outputs", 32'(dut_out()), 32'd0);
      check("t6_async_cnt", 32'(hz.stall_cycles), 32'd0);
      repeat (3) begin
         @(negedge clk);
         if (hz.MD_done) done_at = 1;
      end
      clear_inputs();
      #2 rst_n = 1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (hz.MD_done) done_at = 1;
      end
      check("t6_no_done", 32'(done_at), 32'hFFFFFFFF);
      check("t6_idle", 32'(hz.MD_busy), 32'd0);
      check("t6_cnt_zero", 32'(hz.stall_cycles), 32'd0);
      $display("test 6 async reset done");

      // Randomized traffic against the model.
      next_cycle();
      for (int k = 0; k < 3000; k++) begin
         hz.Ex_MemRead     = $urandom_range(0, 1);
         hz.Ex_Rt          = 5'($urandom_range(0, 3));
         hz.ID_Rs          = 5'($urandom_range(0, 3));
         hz.ID_Rt          = 5'($urandom_range(0, 3));
         hz.Ex_BranchTaken = ($urandom_range(0, 7) == 0);
         hz.Ex_MulDiv      = !hz.Ex_BranchTaken && ($urandom_range(0, 15) == 0);
         hz.Ex_IsDiv       = $urandom_range(0, 1);
         hz.ID_HiLoUse     = $urandom_range(0, 1);
         next_cycle();
      end
      $display("random traffic done");

      // Saturation: 2^16+3 stall cycles.
      reset_pulse();
      hz.Ex_MemRead = 1; hz.Ex_Rt = 1; hz.ID_Rs = 1;
      repeat (65539) @(posedge clk);
      #1;
      check("sat_value", 32'(hz.stall_cycles), 32'h0000FFFF);
      @(negedge clk);
      check("sat_hold", 32'(hz.stall_cycles), 32'h0000FFFF);
      clear_inputs();
      $display("saturation done");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
